// File: rtl/muldiv_ctrl.sv
// Execute-stage sequencer for multi-cycle MULT/MULTU/DIV/DIVU/MUL.
// Feeds operand magnitudes to the shared Mul/Div units, stalls until done, then fixes signs and writes back.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c,
    output logic        div_valid,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [63:0] div_c,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        gpr_valid,
    output logic [31:0] gpr_wdata,
    output logic        timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MUL   = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic          sa_q, sb_q, dz_q, timeout_q;
    logic [31:0]   a_mag_q, b_mag_q;
    logic [63:0]   c_q;
    logic [CW-1:0] cnt_q;

    logic accept, req_signed, req_dz, is_mul_q, done_hit, tmo_hit;

    always_comb begin
        accept     = (state_q == S_IDLE) && req_valid && !flush &&
                     (req_op inside {[OP_MULT:OP_MUL]});
        req_signed = (req_op == OP_MULT) || (req_op == OP_DIV) || (req_op == OP_MUL);
        req_dz     = ((req_op == OP_DIV) || (req_op == OP_DIVU)) && (req_b == 32'd0);
        is_mul_q   = (op_q == OP_MULT) || (op_q == OP_MULTU) || (op_q == OP_MUL);
        done_hit   = is_mul_q ? mul_done : div_done;
        tmo_hit    = (cnt_q == CW'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = req_dz ? S_DONE : S_RUN;
                S_RUN: begin
                    if (done_hit)     state_d = S_DONE;
                    else if (tmo_hit) state_d = S_IDLE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Operand, result and watchdog registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q      <= 3'd0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_q      <= 1'b0;
            a_mag_q   <= 32'd0;
            b_mag_q   <= 32'd0;
            c_q       <= 64'd0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            op_q    <= req_op;
            sa_q    <= req_signed & req_a[31];
            sb_q    <= req_signed & req_b[31];
            dz_q    <= req_dz;
            a_mag_q <= (req_signed && req_a[31]) ? -req_a : req_a;
            b_mag_q <= (req_signed && req_b[31]) ? -req_b : req_b;
            c_q     <= req_dz ? {req_a, 32'hFFFF_FFFF} : 64'd0;
            cnt_q   <= '0;
        end else if (state_q == S_RUN && !flush) begin
            cnt_q <= cnt_q + CW'(1);
            if (done_hit)     c_q <= is_mul_q ? mul_c : div_c;
            else if (tmo_hit) timeout_q <= 1'b1;
        end
    end

    logic [63:0] prod;
    logic [31:0] quo, rem;

    // Outputs; write strobes exist only in DONE and a same-cycle flush kills them
    always_comb begin
        stall     = accept || (state_q == S_RUN);
        busy      = (state_q != S_IDLE);
        mul_valid = (state_q == S_RUN) && is_mul_q;
        div_valid = (state_q == S_RUN) && !is_mul_q;
        mul_a     = a_mag_q;
        mul_b     = b_mag_q;
        div_a     = a_mag_q;
        div_b     = b_mag_q;
        timeout   = timeout_q;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_wdata  = 32'd0;
        lo_wdata  = 32'd0;
        gpr_valid = 1'b0;
        gpr_wdata = 32'd0;
        prod      = (sa_q ^ sb_q) ? -c_q : c_q;
        quo       = (sa_q ^ sb_q) ? -c_q[31:0] : c_q[31:0];
        rem       = sa_q ? -c_q[63:32] : c_q[63:32];
        if (state_q == S_DONE) begin
            case (op_q)
                OP_MULT, OP_MULTU: begin
                    hi_we    = !flush;
                    lo_we    = !flush;
                    hi_wdata = prod[63:32];
                    lo_wdata = prod[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    hi_we    = !flush;
                    lo_we    = !flush;
                    hi_wdata = dz_q ? c_q[63:32] : rem;
                    lo_wdata = dz_q ? c_q[31:0]  : quo;
                end
                OP_MUL: begin
                    gpr_valid = !flush;
                    gpr_wdata = prod[31:0];
                end
                default: ;
            endcase
        end
    end

endmodule
